// File: rtl/rgb_packer_pkg.sv
// Shared types and constants for the RGB byte packer.
// The counter-width helper sizes pixel_count for a given frame geometry.
package rgb_packer_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PUSH    = 1'b1
  } state_t;

  localparam int R_HI = 23;
  localparam int G_HI = 15;
  localparam int B_HI = 7;

  localparam int FRAME_PIXELS_DEFAULT = 720 * 540;

  function automatic int cnt_width(input int width, input int height);
    return (width * height > 1) ? $clog2(width * height) : 1;
  endfunction

endpackage

// File: rtl/rgb_packer.sv
// Packs a byte-serial pixel stream into 24-bit RGB words for the RGB FIFO.
// Define RGB_PACKER_BGR_EN to accept bytes in B,G,R order instead of R,G,B.
module rgb_packer
  import rgb_packer_pkg::*;
#(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 24
) (
  input  logic                                               clock,
  input  logic                                               reset,
  input  logic                                               in_valid,
  input  logic [DWIDTH_IN-1:0]                               in_data,
  output logic                                               in_ready,
  output logic                                               fifo_out_wr_en,
  output logic [DWIDTH_OUT-1:0]                              fifo_out_din,
  input  logic                                               fifo_out_full,
  output logic [cnt_width(IMG_WIDTH, IMG_HEIGHT)-1:0]        pixel_count,
  output logic                                               frame_done
);

  localparam int CW           = cnt_width(IMG_WIDTH, IMG_HEIGHT);
  localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [CW-1:0] LAST_PIXEL = CW'(FRAME_PIXELS - 1);

`ifdef RGB_PACKER_BGR_EN
  localparam int LANE0_HI = B_HI;
  localparam int LANE2_HI = R_HI;
`else
  localparam int LANE0_HI = R_HI;
  localparam int LANE2_HI = B_HI;
`endif
  localparam int LANE1_HI = G_HI;

  state_t                state;
  logic [1:0]            byte_idx;
  logic [DWIDTH_OUT-1:0] pixel;
  logic [DWIDTH_OUT-1:0] next_pixel;
  logic                  transfer;

  // Reset gates both handshakes so nothing moves while it is asserted.
  assign in_ready       = (state == COLLECT) && !reset;
  assign fifo_out_wr_en = (state == PUSH) && !fifo_out_full && !reset;
  assign fifo_out_din   = pixel;
  assign transfer       = in_valid && in_ready;

  // Drop the incoming byte into the lane selected by byte_idx.
  always_comb begin
    next_pixel = pixel;
    case (byte_idx)
      2'd0:    next_pixel[LANE0_HI -: DWIDTH_IN] = in_data;
      2'd1:    next_pixel[LANE1_HI -: DWIDTH_IN] = in_data;
      2'd2:    next_pixel[LANE2_HI -: DWIDTH_IN] = in_data;
      default: next_pixel = pixel;
    endcase
  end

  // Collect/push FSM holding the assembled pixel until the FIFO takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= COLLECT;
      byte_idx <= 2'd0;
      pixel    <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (transfer) begin
            pixel <= next_pixel;
            if (byte_idx == 2'd2) begin
              byte_idx <= 2'd0;
              state    <= PUSH;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        PUSH: begin
          if (fifo_out_wr_en) begin
            state <= COLLECT;
          end
        end
        default: begin
          state    <= COLLECT;
          byte_idx <= 2'd0;
        end
      endcase
    end
  end

  // Per-frame pixel counter; frame_done pulses the cycle after the last write.
  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_count <= '0;
      frame_done  <= 1'b0;
    end else if (fifo_out_wr_en) begin
      if (pixel_count == LAST_PIXEL) begin
        pixel_count <= '0;
        frame_done  <= 1'b1;
      end else begin
        pixel_count <= pixel_count + CW'(1);
        frame_done  <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rgb_packer.sv
// Directed, table-driven bench for rgb_packer on a 4x2 frame.
// Honours RGB_PACKER_BGR_EN by sending each pixel's bytes in B,G,R order.
module tb_rgb_packer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int FRAME = W * H;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        fifo_out_wr_en;
  logic [23:0] fifo_out_din;
  logic        fifo_out_full;
  logic [2:0]  pixel_count;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  rgb_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH_IN(8), .DWIDTH_OUT(24)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fifo_out_wr_en(fifo_out_wr_en), .fifo_out_din(fifo_out_din),
    .fifo_out_full(fifo_out_full), .pixel_count(pixel_count), .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [23:0] rgb;
    int          gap0;
    int          gap1;
    int          gap2;
    int          nfull;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      #1;
      check("gap_in_ready", in_ready, 1);
      check("gap_wr_en", fifo_out_wr_en, 0);
      @(negedge clock);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    #1;
    check("byte_in_ready", in_ready, 1);
    check("byte_wr_en", fifo_out_wr_en, 0);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_pixel(input logic [23:0] rgb, input int g0, input int g1, input int g2);
    logic [7:0] b0, b1, b2;
`ifdef RGB_PACKER_BGR_EN
    b0 = rgb[7:0];   b1 = rgb[15:8]; b2 = rgb[23:16];
`else
    b0 = rgb[23:16]; b1 = rgb[15:8]; b2 = rgb[7:0];
`endif
    gap(g0); send_byte(b0);
    gap(g1); send_byte(b1);
    gap(g2); send_byte(b2);
  endtask

  // Hold the FIFO full for nfull cycles (offering a junk byte), then release it.
  task automatic push_and_check(input logic [23:0] exp_din, input int nfull);
    logic exp_done;
    for (int i = 0; i < nfull; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      fifo_out_full = 1'b1;
      #1;
      check("full_wr_en", fifo_out_wr_en, 0);
      check("full_in_ready", in_ready, 0);
      check("full_din", fifo_out_din, exp_din);
      check("full_count", pixel_count, exp_count);
      check("full_done", frame_done, 0);
      @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = 8'hEE;
    fifo_out_full = 1'b0;
    #1;
    check("push_wr_en", fifo_out_wr_en, 1);
    check("push_din", fifo_out_din, exp_din);
    check("push_in_ready", in_ready, 0);
    @(negedge clock);
    in_valid = 1'b0;
    exp_done  = (exp_count == FRAME - 1);
    exp_count = (exp_count + 1) % FRAME;
    #1;
    check("post_count", pixel_count, exp_count);
    check("post_done", frame_done, exp_done);
    check("post_wr_en", fifo_out_wr_en, 0);
    if (exp_done) begin
      @(negedge clock);
      #1;
      check("done_pulse_end", frame_done, 0);
      check("done_count_zero", pixel_count, 0);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h5A; fifo_out_full = 1'b0;
    @(negedge clock);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", fifo_out_wr_en, 0);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_count", pixel_count, 0);
    check("rst_done", frame_done, 0);
    check("rst_din", fifo_out_din, 0);
    check("rst_in_ready_after", in_ready, 1);

    // rgb, gaps before each byte, cycles of full; 9 pixels wrap the 8-pixel frame.
    vecs[0] = '{24'h112233, 0, 0, 0, 0};
    vecs[1] = '{24'h112233, 0, 0, 0, 5};
    vecs[2] = '{24'hAABBCC, 0, 2, 1, 0};
    vecs[3] = '{24'h000000, 0, 0, 0, 1};
    vecs[4] = '{24'hFFFFFF, 1, 0, 0, 0};
    vecs[5] = '{24'h123456, 0, 1, 0, 2};
    vecs[6] = '{24'h80FF01, 0, 0, 0, 0};
    vecs[7] = '{24'h7E00C3, 0, 0, 3, 0};
    vecs[8] = '{24'hA5965A, 0, 0, 0, 0};
    for (int v = 0; v < 9; v++) begin
      send_pixel(vecs[v].rgb, vecs[v].gap0, vecs[v].gap1, vecs[v].gap2);
      push_and_check(vecs[v].rgb, vecs[v].nfull);
    end

    // Reset mid-pixel discards partial bytes and the frame count.
    send_byte(8'hDE);
    send_byte(8'hAD);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_wr_en", fifo_out_wr_en, 0);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    exp_count = 0;
    #1;
    check("midrst_count", pixel_count, 0);
    check("midrst_done", frame_done, 0);
    send_pixel(24'h010203, 0, 0, 0);
    push_and_check(24'h010203, 0);

    // Reset arriving in PUSH while the FIFO has room must not write.
    send_pixel(24'h445566, 0, 0, 0);
    reset = 1'b1; fifo_out_full = 1'b0;
    #1;
    check("pushrst_wr_en", fifo_out_wr_en, 0);
    check("pushrst_in_ready", in_ready, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("pushrst_count", pixel_count, 0);
    check("pushrst_done", frame_done, 0);
    check("pushrst_din", fifo_out_din, 0);
    check("pushrst_wr_en_after", fifo_out_wr_en, 0);
    check("pushrst_in_ready_after", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
